// File: rtl/vram_write_queue.sv
// Host write queue for the single-port VRAM: buffers pixel writes and commits them only
// during blanking. Optional screen fill is compiled in with `define VRAM_CLEAR_EN.
module vram_write_queue #(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int MEM_WORDS  = 9600
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   output logic              host_ovf,
   output logic              host_range_err,
   input  logic              err_clr,
   input  logic              blank,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_colour,
   output logic              clear_busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t             mem [FIFO_DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               blank_d;
   logic               drain_ok;
   logic               in_range;
   logic               push, pop;
   state_t             state;

   // The first blank cycle is a guard for the registered scan-out address pipeline.
   assign drain_ok   = blank && blank_d;
   assign in_range   = host_addr < ADDR_W'(MEM_WORDS);
   assign host_ready = (count != CNT_W'(FIFO_DEPTH));
   assign push       = host_we && host_ready && in_range;
   assign pop        = (state == DRAIN);
   assign head       = mem[rd_ptr];

   always_ff @(posedge clkin) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         blank_d        <= 1'b0;
         host_ovf       <= 1'b0;
         host_range_err <= 1'b0;
      end else begin
         blank_d <= blank;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // A new error in the same cycle as err_clr keeps the flag set.
         if (host_we && !host_ready) host_ovf <= 1'b1;
         else if (err_clr)           host_ovf <= 1'b0;
         if (host_we && !in_range)   host_range_err <= 1'b1;
         else if (err_clr)           host_range_err <= 1'b0;
      end
   end

   // NOTE: the queue storage has no reset; the pointers and count alone define what is valid.
   always_ff @(posedge clkin) begin
      if (push) mem[wr_ptr] <= '{addr: host_addr, data: host_data};
   end

`ifdef VRAM_CLEAR_EN
   logic [ADDR_W-1:0] fill_ptr;
   logic [DATA_W-1:0] clear_col;

   always_ff @(posedge clkin) begin
      if (rst) begin
         clear_busy <= 1'b0;
         fill_ptr   <= '0;
         clear_col  <= '0;
      end else if (!clear_busy) begin
         if (clear_req) begin
            clear_busy <= 1'b1;
            fill_ptr   <= '0;
            clear_col  <= clear_colour;
         end
      end else if (state == CLEAR) begin
         fill_ptr <= fill_ptr + ADDR_W'(1);
         if (fill_ptr == ADDR_W'(MEM_WORDS - 1)) clear_busy <= 1'b0;
      end
   end
`else
   logic unused_clear;
   assign unused_clear = ^{clear_req, clear_colour};
   assign clear_busy   = 1'b0;
`endif

   // A fill in progress owns every drain slot; the queue only drains once it is done.
   always_comb begin
      state = IDLE;
`ifdef VRAM_CLEAR_EN
      if (clear_busy) begin
         if (drain_ok) state = CLEAR;
      end else
`endif
      if (drain_ok && count != '0) state = DRAIN;
   end

   // NOTE: every output gets a default first so no path leaves a latch behind.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = disp_addr;
      ram_wdata = '0;
      case (state)
         DRAIN: begin
            ram_we    = 1'b1;
            ram_addr  = head.addr;
            ram_wdata = head.data;
         end
`ifdef VRAM_CLEAR_EN
         CLEAR: begin
            ram_we    = 1'b1;
            ram_addr  = fill_ptr;
            ram_wdata = clear_col;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue: a vector table for the basic path and error flags,
// then hand sequences checked against a small queue model of the blank-gated drain.
module tb_vram_write_queue;

   localparam int DEPTH     = 16;
   localparam int MEM_WORDS = 9600;

   logic        clkin = 1'b0;
   logic        rst = 1'b1;
   logic        host_we = 1'b0;
   logic [14:0] host_addr = '0;
   logic [7:0]  host_data = '0;
   logic        host_ready, host_ovf, host_range_err;
   logic        err_clr = 1'b0;
   logic        blank = 1'b0;
   logic [14:0] disp_addr = '0;
   logic        ram_we;
   logic [14:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        clear_req = 1'b0;
   logic [7:0]  clear_colour = '0;
   logic        clear_busy;

   vram_write_queue dut (
      .clkin(clkin), .rst(rst),
      .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
      .host_ready(host_ready), .host_ovf(host_ovf), .host_range_err(host_range_err),
      .err_clr(err_clr), .blank(blank), .disp_addr(disp_addr),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .clear_req(clear_req), .clear_colour(clear_colour), .clear_busy(clear_busy)
   );

   always #5 clkin = ~clkin;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [7:0]  data;
      logic        blk;
      logic        clr;
      logic        e_we;
      logic [14:0] e_addr;
      logic [7:0]  e_data;
      logic        e_rerr;
   } vec_t;

   function automatic vec_t mk(input logic we, input int addr, input int data, input logic blk,
                               input logic clr, input logic e_we, input int e_addr,
                               input int e_data, input logic e_rerr);
      vec_t v;
      v.we = we; v.addr = 15'(addr); v.data = 8'(data); v.blk = blk; v.clr = clr;
      v.e_we = e_we; v.e_addr = 15'(e_addr); v.e_data = 8'(e_data); v.e_rerr = e_rerr;
      return v;
   endfunction

   // Reference model: queued {addr,data}, previous blank, write counter.
   logic [22:0] q[$];
   logic        blank_prev = 1'b0;
   logic        last_we = 1'b0;
   int          wr_seen = 0;

   task automatic cycle(input logic we, input logic [14:0] a, input logic [7:0] d,
                        input logic blk, input logic clr);
      logic        exp_we;
      logic        ready_m;
      logic [22:0] hd;
      logic [14:0] disp;
      disp      = 15'($urandom_range(0, 32767));
      host_we   = we;
      host_addr = a;
      host_data = d;
      blank     = blk;
      err_clr   = clr;
      disp_addr = disp;
      @(negedge clkin);
      ready_m = (q.size() != DEPTH);
      exp_we  = blk && blank_prev && (q.size() > 0);
      check("host_ready", host_ready, ready_m);
      check("ram_we", ram_we, exp_we);
      last_we = ram_we;
      if (exp_we) begin
         hd = q.pop_front();
         check("ram_addr_wr", ram_addr, hd[22:8]);
         check("ram_wdata_wr", ram_wdata, hd[7:0]);
      end else begin
         check("ram_addr_disp", ram_addr, disp);
         check("ram_wdata_idle", ram_wdata, 0);
      end
      if (ram_we) wr_seen++;
      if (we && ready_m && a < 15'(MEM_WORDS)) q.push_back({a, d});
      blank_prev = blk;
      @(posedge clkin); #1;
   endtask

   vec_t tbl[18];

   initial begin
      tbl[0]  = mk(1,    5, 11,   0, 0, 0,    0,    0, 0);
      tbl[1]  = mk(1,    6, 22,   0, 0, 0,    0,    0, 0);
      tbl[2]  = mk(1,    7, 33,   0, 0, 0,    0,    0, 0);
      tbl[3]  = mk(0,    0, 0,    1, 0, 0,    0,    0, 0);
      tbl[4]  = mk(0,    0, 0,    1, 0, 1,    5,   11, 0);
      tbl[5]  = mk(0,    0, 0,    1, 0, 1,    6,   22, 0);
      tbl[6]  = mk(0,    0, 0,    1, 0, 1,    7,   33, 0);
      tbl[7]  = mk(0,    0, 0,    1, 0, 0,    0,    0, 0);
      tbl[8]  = mk(0,    0, 0,    0, 0, 0,    0,    0, 0);
      tbl[9]  = mk(1, 9600, 8'h55, 0, 0, 0,   0,    0, 0);
      tbl[10] = mk(1, 9599, 8'h2A, 0, 0, 0,   0,    0, 1);
      tbl[11] = mk(0,    0, 0,    1, 0, 0,    0,    0, 1);
      tbl[12] = mk(0,    0, 0,    1, 0, 1, 9599, 8'h2A, 1);
      tbl[13] = mk(0,    0, 0,    1, 0, 0,    0,    0, 1);
      tbl[14] = mk(0,    0, 0,    0, 1, 0,    0,    0, 1);
      tbl[15] = mk(1, 9700, 0,    0, 1, 0,    0,    0, 0);
      tbl[16] = mk(0,    0, 0,    0, 1, 0,    0,    0, 1);
      tbl[17] = mk(0,    0, 0,    0, 0, 0,    0,    0, 0);

      repeat (3) @(posedge clkin);
      #1 rst = 1'b0;

      // Basic queue-then-drain path, range errors and flag clearing.
      for (int i = 0; i < 18; i++) begin
         host_we   = tbl[i].we;
         host_addr = tbl[i].addr;
         host_data = tbl[i].data;
         blank     = tbl[i].blk;
         err_clr   = tbl[i].clr;
         disp_addr = 15'(100 + i);
         @(negedge clkin);
         check($sformatf("vec%0d_we", i), ram_we, tbl[i].e_we);
         check($sformatf("vec%0d_addr", i), ram_addr,
               tbl[i].e_we ? tbl[i].e_addr : 15'(100 + i));
         check($sformatf("vec%0d_wdata", i), ram_wdata, tbl[i].e_data);
         check($sformatf("vec%0d_ready", i), host_ready, 1);
         check($sformatf("vec%0d_ovf", i), host_ovf, 0);
         check($sformatf("vec%0d_rerr", i), host_range_err, tbl[i].e_rerr);
         check($sformatf("vec%0d_busy", i), clear_busy, 0);
         @(posedge clkin); #1;
      end
      blank_prev = 1'b0;

      // Fill to 16, overflow on the 17th, drain exactly 16, clear the flag.
      for (int i = 0; i < 16; i++) cycle(1, 15'(300 + i), 8'(i + 1), 0, 0);
      check("ovf_before_17th", host_ovf, 0);
      cycle(1, 15'd400, 8'h77, 0, 0);
      check("ready_when_full", host_ready, 0);
      check("ovf_after_17th", host_ovf, 1);
      wr_seen = 0;
      for (int i = 0; i < 20; i++) cycle(0, '0, '0, 1, 0);
      check("drain_count_16", wr_seen, 16);
      cycle(0, '0, '0, 0, 1);
      check("ovf_cleared", host_ovf, 0);

      // Short blank: 1 guard + 3 writes, none on the falling edge, rest later.
      for (int i = 0; i < 10; i++) cycle(1, 15'(100 + i), 8'(8'h40 + i), 0, 0);
      wr_seen = 0;
      for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0);
      check("short_blank_writes", wr_seen, 3);
      cycle(0, '0, '0, 0, 0);
      check("we_on_blank_fall", last_we, 0);
      wr_seen = 0;
      cycle(0, '0, '0, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, '0, '0, 1, 0);
      check("second_blank_writes", wr_seen, 7);

      // Concurrent push and pop with 8 queued: occupancy stays at 8.
      for (int i = 0; i < 8; i++) cycle(1, 15'(200 + i), 8'(8'h80 + i), 0, 0);
      cycle(0, '0, '0, 1, 0);
      for (int i = 0; i < 8; i++) cycle(1, 15'(208 + i), 8'(8'h88 + i), 1, 0);
      cycle(0, '0, '0, 0, 0);
      wr_seen = 0;
      for (int i = 0; i < 12; i++) cycle(0, '0, '0, 1, 0);
      check("concurrent_remaining", wr_seen, 8);
      cycle(0, '0, '0, 0, 0);

`ifdef VRAM_CLEAR_EN
      begin
         int n   = 0;
         int bad = 0;
         int cyc = 0;
         logic [22:0] hd;
         cycle(1, 15'd42, 8'h12, 0, 0);
         cycle(1, 15'd43, 8'h34, 0, 0);
         clear_req    = 1'b1;
         clear_colour = 8'h3F;
         blank        = 1'b1;
         @(posedge clkin); #1;
         clear_req    = 1'b0;
         clear_colour = 8'h00;
         check("clear_busy_set", clear_busy, 1);
         while (n < MEM_WORDS + 2 && cyc < 12000) begin
            @(negedge clkin);
            if (ram_we) begin
               if (n < MEM_WORDS) begin
                  if (ram_addr !== 15'(n) || ram_wdata !== 8'h3F) bad++;
               end else begin
                  if (n == MEM_WORDS) check("clear_busy_done", clear_busy, 0);
                  hd = q.pop_front();
                  check("post_clear_addr", ram_addr, hd[22:8]);
                  check("post_clear_data", ram_wdata, hd[7:0]);
               end
               n++;
            end
            cyc++;
            @(posedge clkin); #1;
         end
         check("clear_total_writes", n, MEM_WORDS + 2);
         check("clear_bad_writes", bad, 0);
         blank_prev = 1'b1;
      end
`else
      clear_req    = 1'b1;
      clear_colour = 8'h3F;
      cycle(0, '0, '0, 1, 0);
      clear_req = 1'b0;
      wr_seen   = 0;
      for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0);
      check("clear_ignored_busy", clear_busy, 0);
      check("clear_ignored_writes", wr_seen, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
